// File: rtl/svc_rv_pkg.sv
// Shared RV pipeline encodings: register index width and MEM-stage result-source selects.
package svc_rv_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 1 << REG_IDX_W;

  typedef enum logic [2:0] {
    RES_ALU = 3'd0,
    RES_LD  = 3'd1,
    RES_PC4 = 3'd2,
    RES_IMM = 3'd3,
    RES_CSR = 3'd4
  } res_src_e;

endpackage

// File: rtl/svc_rv_fwd_port.sv
// One ID source operand: picks the freshest value for rs and flags whether it
// cannot be supplied this cycle.
module svc_rv_fwd_port
  import svc_rv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MEM_TYPE = 0
) (
  input  logic [REG_IDX_W-1:0] rs,
  input  logic [XLEN-1:0]      rs_data,
  input  logic                 rs_busy,
  input  logic [REG_IDX_W-1:0] rd_ex,
  input  logic                 reg_write_ex,
  input  logic [REG_IDX_W-1:0] rd_mem,
  input  logic                 reg_write_mem,
  input  logic [2:0]           res_src_mem,
  input  logic [XLEN-1:0]      result_mem,
  input  logic [XLEN-1:0]      ld_data_mem,
  input  logic [REG_IDX_W-1:0] rd_wb,
  input  logic                 reg_write_wb,
  input  logic [XLEN-1:0]      rd_data_wb,
  input  logic                 cmpl_valid,
  input  logic [REG_IDX_W-1:0] cmpl_rd,
  input  logic [XLEN-1:0]      cmpl_data,
  output logic [XLEN-1:0]      fwd_data,
  output logic                 stall
);

  logic rs_nz;
  logic ex_match;
  logic mem_match;
  logic cmpl_match;
  logic wb_match;
  logic mem_ld;
  logic [XLEN-1:0] mem_val;

  assign rs_nz      = (rs != '0);
  assign ex_match   = rs_nz && reg_write_ex && (rd_ex == rs);
  assign mem_match  = rs_nz && reg_write_mem && (rd_mem == rs) && (rd_mem != '0);
  assign cmpl_match = rs_nz && cmpl_valid && (cmpl_rd == rs);
  assign wb_match   = rs_nz && reg_write_wb && (rd_wb == rs);
  assign mem_ld     = (res_src_mem == RES_LD);

  // Registered-memory loads only carry an address in MEM; the stall covers that case.
  assign mem_val = (mem_ld && (MEM_TYPE == 0)) ? ld_data_mem : result_mem;

  always_comb begin
    fwd_data = rs_data;
    if (!rs_nz)          fwd_data = '0;
    else if (mem_match)  fwd_data = mem_val;
    else if (cmpl_match) fwd_data = cmpl_data;
    else if (wb_match)   fwd_data = rd_data_wb;
  end

  always_comb begin
    stall = 1'b0;
    if (ex_match)                                   stall = 1'b1;
    if (mem_match && (res_src_mem == RES_CSR))      stall = 1'b1;
    if (mem_match && mem_ld && (MEM_TYPE != 0))     stall = 1'b1;
    if (rs_nz && rs_busy && !cmpl_match)            stall = 1'b1;
  end

endmodule

// File: rtl/svc_rv_fwd_sb.sv
// ID-stage operand resolver: NRD forwarding ports, a long-latency producer
// scoreboard, the combined ID stall and a saturating stall-cycle counter.
module svc_rv_fwd_sb
  import svc_rv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NRD      = 2,
  parameter int MEM_TYPE = 0,
  parameter int CNT_W    = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NRD*REG_IDX_W-1:0]  rs_id,
  input  logic [NRD*XLEN-1:0]       rs_data_id,
  input  logic [REG_IDX_W-1:0]      rd_id,
  input  logic                      reg_write_id,
  input  logic [REG_IDX_W-1:0]      rd_ex,
  input  logic                      reg_write_ex,
  input  logic [REG_IDX_W-1:0]      rd_mem,
  input  logic                      reg_write_mem,
  input  logic [2:0]                res_src_mem,
  input  logic [XLEN-1:0]           result_mem,
  input  logic [XLEN-1:0]           ld_data_mem,
  input  logic [REG_IDX_W-1:0]      rd_wb,
  input  logic                      reg_write_wb,
  input  logic [XLEN-1:0]           rd_data_wb,
  input  logic                      issue_valid,
  input  logic [REG_IDX_W-1:0]      issue_rd,
  input  logic                      cmpl_valid,
  input  logic [REG_IDX_W-1:0]      cmpl_rd,
  input  logic [XLEN-1:0]           cmpl_data,
  output logic [NRD*XLEN-1:0]       fwd_rs_id,
  output logic                      stall_id,
  output logic [NUM_REGS-1:0]       busy,
  output logic [CNT_W-1:0]          stall_cnt
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;
  logic [NRD-1:0]      port_stall;
  logic                waw_stall;

  for (genvar i = 0; i < NRD; i++) begin : g_port
    logic [REG_IDX_W-1:0] rs_i;
    assign rs_i = rs_id[REG_IDX_W*i +: REG_IDX_W];

    svc_rv_fwd_port #(
      .XLEN     (XLEN),
      .MEM_TYPE (MEM_TYPE)
    ) u_port (
      .rs            (rs_i),
      .rs_data       (rs_data_id[XLEN*i +: XLEN]),
      .rs_busy       (busy_q[rs_i]),
      .rd_ex         (rd_ex),
      .reg_write_ex  (reg_write_ex),
      .rd_mem        (rd_mem),
      .reg_write_mem (reg_write_mem),
      .res_src_mem   (res_src_mem),
      .result_mem    (result_mem),
      .ld_data_mem   (ld_data_mem),
      .rd_wb         (rd_wb),
      .reg_write_wb  (reg_write_wb),
      .rd_data_wb    (rd_data_wb),
      .cmpl_valid    (cmpl_valid),
      .cmpl_rd       (cmpl_rd),
      .cmpl_data     (cmpl_data),
      .fwd_data      (fwd_rs_id[XLEN*i +: XLEN]),
      .stall         (port_stall[i])
    );
  end

  // A completion landing this cycle retires the older writer, so no WAW hazard remains.
  assign waw_stall = reg_write_id && (rd_id != '0) && busy_q[rd_id]
                     && !(cmpl_valid && (cmpl_rd == rd_id));
  assign stall_id  = (|port_stall) || waw_stall;

  // Clear before set: a same-edge issue to the completing rd is the newer producer.
  always_comb begin
    busy_d = busy_q;
    if (cmpl_valid)  busy_d[cmpl_rd]  = 1'b0;
    if (issue_valid) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                stall_cnt <= '0;
    else if (stall_id && (stall_cnt != '1))    stall_cnt <= stall_cnt + 1'b1;
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_svc_rv_fwd_sb.sv
// Bench for svc_rv_fwd_sb: three instances (load-forwarding, registered memory,
// 3-bit counter) share stimulus and are compared every cycle against a reference model.
module tb_svc_rv_fwd_sb;

  localparam int XLEN = 32;
  localparam int NRD  = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [4:0]      rs_a [NRD];
  logic [XLEN-1:0] rs_data_a [NRD];
  logic [4:0]  rd_id, rd_ex, rd_mem, rd_wb, issue_rd, cmpl_rd;
  logic        reg_write_id, reg_write_ex, reg_write_mem, reg_write_wb, issue_valid, cmpl_valid;
  logic [2:0]  res_src_mem;
  logic [XLEN-1:0] result_mem, ld_data_mem, rd_data_wb, cmpl_data;

  logic [NRD*5-1:0]    rs_id;
  logic [NRD*XLEN-1:0] rs_data_id;
  assign rs_id      = {rs_a[1], rs_a[0]};
  assign rs_data_id = {rs_data_a[1], rs_data_a[0]};

  logic [NRD*XLEN-1:0] fwd0, fwd1, fwd2;
  logic        stall0, stall1, stall2;
  logic [31:0] busy0, busy1, busy2;
  logic [31:0] cnt0, cnt1;
  logic [2:0]  cnt2;

  svc_rv_fwd_sb #(.XLEN(XLEN), .NRD(NRD), .MEM_TYPE(0), .CNT_W(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .rs_id(rs_id), .rs_data_id(rs_data_id),
    .rd_id(rd_id), .reg_write_id(reg_write_id), .rd_ex(rd_ex), .reg_write_ex(reg_write_ex),
    .rd_mem(rd_mem), .reg_write_mem(reg_write_mem), .res_src_mem(res_src_mem),
    .result_mem(result_mem), .ld_data_mem(ld_data_mem), .rd_wb(rd_wb),
    .reg_write_wb(reg_write_wb), .rd_data_wb(rd_data_wb), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .cmpl_valid(cmpl_valid), .cmpl_rd(cmpl_rd), .cmpl_data(cmpl_data),
    .fwd_rs_id(fwd0), .stall_id(stall0), .busy(busy0), .stall_cnt(cnt0));

  svc_rv_fwd_sb #(.XLEN(XLEN), .NRD(NRD), .MEM_TYPE(1), .CNT_W(32)) dut1 (
    .clk(clk), .rst_n(rst_n), .rs_id(rs_id), .rs_data_id(rs_data_id),
    .rd_id(rd_id), .reg_write_id(reg_write_id), .rd_ex(rd_ex), .reg_write_ex(reg_write_ex),
    .rd_mem(rd_mem), .reg_write_mem(reg_write_mem), .res_src_mem(res_src_mem),
    .result_mem(result_mem), .ld_data_mem(ld_data_mem), .rd_wb(rd_wb),
    .reg_write_wb(reg_write_wb), .rd_data_wb(rd_data_wb), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .cmpl_valid(cmpl_valid), .cmpl_rd(cmpl_rd), .cmpl_data(cmpl_data),
    .fwd_rs_id(fwd1), .stall_id(stall1), .busy(busy1), .stall_cnt(cnt1));

  svc_rv_fwd_sb #(.XLEN(XLEN), .NRD(NRD), .MEM_TYPE(0), .CNT_W(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .rs_id(rs_id), .rs_data_id(rs_data_id),
    .rd_id(rd_id), .reg_write_id(reg_write_id), .rd_ex(rd_ex), .reg_write_ex(reg_write_ex),
    .rd_mem(rd_mem), .reg_write_mem(reg_write_mem), .res_src_mem(res_src_mem),
    .result_mem(result_mem), .ld_data_mem(ld_data_mem), .rd_wb(rd_wb),
    .reg_write_wb(reg_write_wb), .rd_data_wb(rd_data_wb), .issue_valid(issue_valid),
    .issue_rd(issue_rd), .cmpl_valid(cmpl_valid), .cmpl_rd(cmpl_rd), .cmpl_data(cmpl_data),
    .fwd_rs_id(fwd2), .stall_id(stall2), .busy(busy2), .stall_cnt(cnt2));

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_busy;
  longint      m_cnt0, m_cnt1, m_cnt2;
  bit          mon_en = 1'b0;

  function automatic bit exp_stall(input int mt);
    bit s = 0;
    for (int i = 0; i < NRD; i++) begin
      int r = int'(rs_a[i]);
      if (r != 0) begin
        bit memm = reg_write_mem && (int'(rd_mem) == r);
        if (reg_write_ex && int'(rd_ex) == r) s = 1;
        if (memm && res_src_mem == 3'd4) s = 1;
        if (memm && res_src_mem == 3'd1 && mt == 1) s = 1;
        if (m_busy[r] && !(cmpl_valid && int'(cmpl_rd) == r)) s = 1;
      end
    end
    if (reg_write_id && rd_id != 0 && m_busy[rd_id] && !(cmpl_valid && cmpl_rd == rd_id)) s = 1;
    return s;
  endfunction

  function automatic logic [XLEN-1:0] exp_op(input int i);
    int r = int'(rs_a[i]);
    if (r == 0) return '0;
    if (reg_write_mem && int'(rd_mem) == r) return (res_src_mem == 3'd1) ? ld_data_mem : result_mem;
    if (cmpl_valid && int'(cmpl_rd) == r) return cmpl_data;
    if (reg_write_wb && int'(rd_wb) == r) return rd_data_wb;
    return rs_data_a[i];
  endfunction

  function automatic logic [31:0] next_busy();
    logic [31:0] nb = m_busy;
    if (cmpl_valid) nb[cmpl_rd] = 1'b0;
    if (issue_valid && issue_rd != 0) nb[issue_rd] = 1'b1;
    return nb;
  endfunction

  function automatic longint sat_inc(input longint v, input int w);
    longint mx = (longint'(1) << w) - 1;
    return (v >= mx) ? mx : v + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= '0;
      m_cnt0 <= 0; m_cnt1 <= 0; m_cnt2 <= 0;
    end else begin
      m_busy <= next_busy();
      if (exp_stall(0)) begin
        m_cnt0 <= sat_inc(m_cnt0, 32);
        m_cnt2 <= sat_inc(m_cnt2, 3);
      end
      if (exp_stall(1)) m_cnt1 <= sat_inc(m_cnt1, 32);
    end
  end

  // Operands are only meaningful on cycles the instance does not stall.
  always @(negedge clk) begin
    if (mon_en) begin
      check("m_stall0", 64'(stall0), 64'(exp_stall(0)));
      check("m_stall1", 64'(stall1), 64'(exp_stall(1)));
      check("m_stall2", 64'(stall2), 64'(exp_stall(0)));
      check("m_busy0", 64'(busy0), 64'(m_busy));
      check("m_busy1", 64'(busy1), 64'(m_busy));
      check("m_busy2", 64'(busy2), 64'(m_busy));
      check("m_cnt0", 64'(cnt0), 64'(m_cnt0));
      check("m_cnt1", 64'(cnt1), 64'(m_cnt1));
      check("m_cnt2", 64'(cnt2), 64'(m_cnt2));
      for (int i = 0; i < NRD; i++) begin
        if (!exp_stall(0)) begin
          check("m_op0", 64'(fwd0[XLEN*i +: XLEN]), 64'(exp_op(i)));
          check("m_op2", 64'(fwd2[XLEN*i +: XLEN]), 64'(exp_op(i)));
        end
        if (!exp_stall(1)) check("m_op1", 64'(fwd1[XLEN*i +: XLEN]), 64'(exp_op(i)));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    for (int i = 0; i < NRD; i++) begin
      rs_a[i] = '0;
      rs_data_a[i] = 32'h1000_0000 + 32'(i);
    end
    rd_id = 0; reg_write_id = 0; rd_ex = 0; reg_write_ex = 0;
    rd_mem = 0; reg_write_mem = 0; res_src_mem = 0; result_mem = 0; ld_data_mem = 0;
    rd_wb = 0; reg_write_wb = 0; rd_data_wb = 0;
    issue_valid = 0; issue_rd = 0; cmpl_valid = 0; cmpl_rd = 0; cmpl_data = 0;
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    step(2);
    mon_en = 1'b1;
    check("rst_busy", 64'(busy0), 64'h0);
    check("rst_cnt", 64'(cnt0), 64'h0);
    rst_n = 1'b1;
    step(1);

    // EX-stage producer on port1: 5 stalls, then 5 more to saturate the 3-bit counter.
    rd_ex = 5'd3; reg_write_ex = 1; rs_a[1] = 5'd3;
    #1 check("ex_stall", 64'(stall0), 64'h1);
    step(5);
    check("cnt5", 64'(cnt0), 64'd5);
    check("cnt5_w3", 64'(cnt2), 64'd5);
    step(5);
    check("cnt10", 64'(cnt0), 64'd10);
    check("cnt_sat", 64'(cnt2), 64'd7);
    clear_inputs();
    step(1);

    // MEM beats WB; unrelated port reads the register file.
    rs_a[0] = 5'd10; rs_a[1] = 5'd2;
    rs_data_a[0] = 32'hAAAA_0001; rs_data_a[1] = 32'hBBBB_0002;
    rd_mem = 5'd10; reg_write_mem = 1; res_src_mem = 3'd0; result_mem = 32'h1111_0000;
    rd_wb = 5'd10; reg_write_wb = 1; rd_data_wb = 32'h2222_0000;
    #1;
    check("mem_alu", 64'(fwd0[31:0]), 64'h1111_0000);
    check("rf_port1", 64'(fwd0[63:32]), 64'hBBBB_0002);
    check("mem_alu_stall", 64'(stall0), 64'h0);
    step(1);
    reg_write_mem = 0;
    #1 check("wb_fwd", 64'(fwd0[31:0]), 64'h2222_0000);
    step(1);

    // Load in MEM: forwarded with MEM_TYPE=0, stalls with registered memory.
    reg_write_mem = 1; res_src_mem = 3'd1; ld_data_mem = 32'hCAFE_BABE; result_mem = 32'h0000_0040;
    #1;
    check("ld_fwd", 64'(fwd0[31:0]), 64'hCAFE_BABE);
    check("ld_nostall", 64'(stall0), 64'h0);
    check("ld_stall_regmem", 64'(stall1), 64'h1);
    step(1);
    res_src_mem = 3'd4;
    #1 check("csr_stall", 64'(stall0), 64'h1);
    clear_inputs();
    step(1);

    // Long op to x5: issued while still in EX, then busy until completion.
    issue_valid = 1; issue_rd = 5'd5; reg_write_ex = 1; rd_ex = 5'd5; rs_a[0] = 5'd5;
    step(1);
    issue_valid = 0; reg_write_ex = 0;
    #1;
    check("busy5_set", 64'(busy0[5]), 64'h1);
    for (int k = 0; k < 3; k++) begin
      check("busy5_stall", 64'(stall0), 64'h1);
      step(1);
    end
    cmpl_valid = 1; cmpl_rd = 5'd5; cmpl_data = 32'hDEAD_BEEF;
    #1;
    check("cmpl_fwd", 64'(fwd0[31:0]), 64'hDEAD_BEEF);
    check("cmpl_nostall", 64'(stall0), 64'h0);
    step(1);
    cmpl_valid = 0;
    #1 check("busy5_clr", 64'(busy0[5]), 64'h0);
    clear_inputs();
    step(1);

    // Same-edge issue and completion on x7 leaves it busy; WAW from ID.
    issue_valid = 1; issue_rd = 5'd7; cmpl_valid = 1; cmpl_rd = 5'd7; cmpl_data = 32'h7;
    step(1);
    issue_valid = 0; cmpl_valid = 0;
    rd_id = 5'd7; reg_write_id = 1;
    #1;
    check("busy7_kept", 64'(busy0[7]), 64'h1);
    check("waw_stall", 64'(stall0), 64'h1);
    step(1);
    cmpl_valid = 1; cmpl_rd = 5'd7; cmpl_data = 32'h77;
    #1 check("waw_cmpl", 64'(stall0), 64'h0);
    step(1);
    clear_inputs();
    issue_valid = 1; issue_rd = 5'd0;
    step(1);
    issue_valid = 0;
    #1 check("busy0_never", 64'(busy0[0]), 64'h0);

    // Async reset mid-cycle with x9 busy.
    issue_valid = 1; issue_rd = 5'd9;
    step(1);
    issue_valid = 0;
    check("busy9_set", 64'(busy0[9]), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy_async", 64'(busy0), 64'h0);
    check("rst_cnt_async", 64'(cnt0), 64'h0);
    check("rst_cnt2_async", 64'(cnt2), 64'h0);
    rs_a[0] = 5'd9;
    #1 check("rst_no_stall", 64'(stall0), 64'h0);
    rs_a[0] = 5'd0; rd_wb = 5'd0; reg_write_wb = 1; rd_data_wb = 32'h1234_5678;
    #1 check("x0_zero", 64'(fwd0[31:0]), 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_inputs();
    step(3);

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/svc_rv_fwd_sb.md
# svc_rv_fwd_sb

Parametrised ID-stage operand resolver for the RV pipeline: forwards from MEM, long-latency completion and WB into NRD register read ports, and tracks long-latency producers (divider, CSR, multi-cycle units) in a per-register scoreboard. It raises a single ID stall on any operand that cannot yet be supplied (EX producer, unready MEM load or CSR, busy scoreboard entry, WAW on a busy entry), and keeps a saturating stall-cycle counter. It sits beside the register file in ID, between decode and the ID/EX pipeline register.

## Interface
- XLEN, 32, data width
- NRD, 2, number of ID source-operand ports (1..4)
- MEM_TYPE, 0, 0 = load data valid in MEM (forwardable); 1 = registered memory, load data not valid until WB
- CNT_W, 32, stall counter width
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rs_id  in  NRD*5  source register indices, port i at [5i+:5]
- rs_data_id  in  NRD*XLEN  register-file read data
- rd_id, reg_write_id  in  5, 1  destination of the instruction in ID (WAW check)
- rd_ex, reg_write_ex  in  5, 1  EX-stage producer
- rd_mem, reg_write_mem, res_src_mem  in  5, 1, 3  MEM-stage producer
- result_mem, ld_data_mem  in  XLEN each  MEM ALU/pc-class result, load data
- rd_wb, reg_write_wb, rd_data_wb  in  5, 1, XLEN  WB write port
- issue_valid, issue_rd  in  1, 5  long op leaving EX for MEM (past last flush point)
- cmpl_valid, cmpl_rd, cmpl_data  in  1, 5, XLEN  long op result; also written to regfile this cycle
- fwd_rs_id  out  NRD*XLEN  resolved operands
- stall_id  out  1  hold ID/IF, bubble EX
- busy  out  32  scoreboard, bit 0 constant 0
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- Per port i, source priority: rs==0 -> 0; MEM match -> MEM value; completion match -> cmpl_data; WB match -> rd_data_wb; else rs_data_id.
- MEM match: reg_write_mem && rd_mem==rs && rd_mem!=0. Value: result_mem for RES_ALU/RES_PC4/RES_IMM; ld_data_mem for RES_LD when MEM_TYPE=0.
- Stall causes, per port with rs!=0: EX match (reg_write_ex, rd_ex==rs); MEM match with res_src_mem==RES_CSR; MEM match with RES_LD and MEM_TYPE=1; busy[rs] && !(cmpl_valid && cmpl_rd==rs). WAW: reg_write_id && rd_id!=0 && busy[rd_id] && not completing this cycle.
- Long ops reach MEM/WB with reg_write=0; their only write path is cmpl_*.
- Scoreboard per edge: issue_valid sets busy[issue_rd]; cmpl_valid clears busy[cmpl_rd]; same rd both -> stays set (issue newer). Completion to a non-busy rd: data still forwarded, bit unchanged. rd 0 never set.
- stall_cnt increments on each cycle stall_id=1, holds at all-ones.

## Timing
- Forwarding and stall_id combinational from inputs and busy; zero latency.
- busy changes one edge after issue/completion; completion data forwarded in its own cycle, so no stall that cycle.
- Issue to busy-visible gap is covered by the EX-match stall (op still in EX when issue presented).
- Reset (async, any time): busy=0, stall_cnt=0; stall_id, fwd_rs_id follow inputs immediately; in-flight long ops are discarded.

## Structure
- Package svc_rv_pkg: res_src encodings (RES_ALU=0, RES_LD=1, RES_PC4=2, RES_IMM=3, RES_CSR=4), register-index width constant.
- Sub-module svc_rv_fwd_port: one operand's match/priority/stall logic, instantiated NRD times by generate; scoreboard and counter in the top.

## Test plan
- rs=10/2, MEM rd=10 RES_ALU 0x11110000, WB rd=10 0x22220000 -> port0 0x11110000, port1 rs_data, stall_id=0.
- MEM rd=10 RES_LD ld_data 0xCAFEBABE: MEM_TYPE=0 -> forwarded, no stall; MEM_TYPE=1 -> stall_id=1.
- issue_valid rd=5; next cycle rs=5 -> stall_id=1 each cycle; cmpl_valid rd=5 data 0xDEADBEEF -> operand 0xDEADBEEF, stall_id=0, busy[5]=0 next cycle.
- Same-edge issue rd=7 and cmpl rd=7 -> busy[7]=1 after edge; rd_id=7 reg_write_id=1 -> WAW stall.
- EX rd=3 match on port1, 5 stall cycles -> stall_cnt=5; CNT_W=3 with 10 stalls -> saturates at 7.
- busy[9] set, rst_n low mid-cycle -> busy=0, stall_cnt=0 immediately; rs=9 no stall; rs=0 with WB rd=0 -> operand 0.
